// File: rtl/idecode_sb_pkg.sv
// idecode_sb shared definitions: instruction field positions, register-number
// width derivation and the opcode/immediate decode helpers.
// Optional build macro IDECODE_WB_FWD_EN (same-cycle WB bypass) is consumed by
// the scoreboard and the top; nothing here depends on it.
package idecode_sb_pkg;

    // Helpers take operands zero-padded to this width so they serve any legal
    // parameter set; callers truncate the result back to their own widths.
    localparam int MAXW = 64;

    function automatic int w_rd_of(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    // Field layout from the MSB down: opc, immf, rd, rs.
    function automatic int opc_lsb(input int word, input int w_opc);
        return word - w_opc;
    endfunction

    function automatic int immf_bit(input int word, input int w_opc);
        return word - w_opc - 1;
    endfunction

    function automatic int rd_lsb(input int word, input int w_opc, input int w_rd);
        return word - w_opc - 1 - w_rd;
    endfunction

    function automatic int rs_lsb(input int word, input int w_opc, input int w_rd);
        return word - w_opc - 1 - 2 * w_rd;
    endfunction

    // Decoded opcode: logical-group flag (opc MSB) above the 3-bit ALU selector.
    function automatic logic [MAXW-1:0] decode_ope(input logic [MAXW-1:0] opc, input int w_opc);
        return (MAXW'(opc[w_opc-1]) << 3) | (opc & MAXW'(7));
    endfunction

    // Opcodes with the bit below the MSB set (stores, branches) write no register.
    function automatic logic has_wb(input logic [MAXW-1:0] opc, input int w_opc);
        return ~opc[w_opc-2];
    endfunction

    // Logical group zero-extends, everything else sign-extends.
    function automatic logic [MAXW-1:0] expand_imm(input logic [MAXW-1:0] imm, input int w_imm,
                                                   input logic zext);
        logic [MAXW-1:0] mask;
        logic [MAXW-1:0] val;
        mask = (MAXW'(1) << w_imm) - MAXW'(1);
        val  = imm & mask;
        if (!zext && imm[w_imm-1]) val = val | ~mask;
        return val;
    endfunction

endpackage

// File: rtl/idecode_sb_if.sv
// idecode_sb bus bundle: IF handshake, regfile read ports, WB snoop and the
// EX-bound decoded instruction. master = surrounding pipeline, slave = ID.
interface idecode_sb_if #(
    parameter int WORD   = 32,
    parameter int ADDR   = 32,
    parameter int NREG   = 8,
    parameter int W_OPC  = 6,
    parameter int W_DOPC = 4
);
    import idecode_sb_pkg::*;

    localparam int W_RD = w_rd_of(NREG);

    logic              v_i;
    logic              stall_o;
    logic [WORD-1:0]   inst_i;
    logic [ADDR-1:0]   origaddr_i;
    logic              flush_i;
    logic [W_RD-1:0]   r0_num_o;
    logic [W_RD-1:0]   r1_num_o;
    logic [WORD-1:0]   r0_data_i;
    logic [WORD-1:0]   r1_data_i;
    logic              wb_v_i;
    logic [W_RD-1:0]   wb_num_i;
    logic [WORD-1:0]   wb_data_i;
    logic              v_o;
    logic              stall_i;
    logic [WORD-1:0]   src_o;
    logic [WORD-1:0]   dest_o;
    logic              wb_o;
    logic [W_RD-1:0]   rd_num_o;
    logic [W_DOPC-1:0] dopc_o;
    logic [W_OPC-1:0]  opc_o;
    logic [ADDR-1:0]   origaddr_o;

    modport master (
        output v_i, inst_i, origaddr_i, flush_i, r0_data_i, r1_data_i,
               wb_v_i, wb_num_i, wb_data_i, stall_i,
        input  stall_o, r0_num_o, r1_num_o, v_o, src_o, dest_o, wb_o,
               rd_num_o, dopc_o, opc_o, origaddr_o
    );

    modport slave (
        input  v_i, inst_i, origaddr_i, flush_i, r0_data_i, r1_data_i,
               wb_v_i, wb_num_i, wb_data_i, stall_i,
        output stall_o, r0_num_o, r1_num_o, v_o, src_o, dest_o, wb_o,
               rd_num_o, dopc_o, opc_o, origaddr_o
    );
endinterface

// File: rtl/idecode_sb_scoreboard.sv
// idecode_scoreboard: per-register busy bits for in-flight writers.
// Priority per bit: flush kill > capture set > WB clear.
// IDECODE_WB_FWD_EN: a source being retired by WB this cycle is not a hazard
// and the match outputs steer the WB data into the operand registers.
module idecode_scoreboard #(
    parameter int NREG = 8,
    parameter int W_RD = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_v,
    input  logic [W_RD-1:0] set_num,
    input  logic            clr_v,
    input  logic [W_RD-1:0] clr_num,
    input  logic            kill_v,
    input  logic [W_RD-1:0] kill_num,
    input  logic [W_RD-1:0] rd_num,
    input  logic [W_RD-1:0] rs_num,
    input  logic            rs_used,
    output logic            rd_hz,
    output logic            rs_hz,
    output logic            rd_fwd,
    output logic            rs_fwd
);

    logic [NREG-1:0] busy;

    // Busy vector update; the flush kill of the squashed writer overrides all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (kill_v && kill_num == W_RD'(i))     busy[i] <= 1'b0;
                else if (set_v && set_num == W_RD'(i))  busy[i] <= 1'b1;
                else if (clr_v && clr_num == W_RD'(i))  busy[i] <= 1'b0;
            end
        end
    end

`ifdef IDECODE_WB_FWD_EN
    logic rd_match;
    logic rs_match;

    // A register retired by WB this cycle is readable from the WB bus.
    always_comb begin
        rd_match = clr_v && (clr_num == rd_num);
        rs_match = clr_v && (clr_num == rs_num);
        rd_hz    = busy[rd_num] & ~rd_match;
        rs_hz    = rs_used & busy[rs_num] & ~rs_match;
        rd_fwd   = rd_match;
        rs_fwd   = rs_used & rs_match;
    end
`else
    // Without bypass any busy operand waits for the cycle after its WB.
    always_comb begin
        rd_hz  = busy[rd_num];
        rs_hz  = rs_used & busy[rs_num];
        rd_fwd = 1'b0;
        rs_fwd = 1'b0;
    end
`endif

endmodule

// File: rtl/idecode_sb.sv
// idecode_sb: decode stage with a local register scoreboard.
// Splits the instruction, reads rd/rs through the regfile, stalls IF on RAW/WAW
// hazards against in-flight writers and registers decoded operands for EX.
// Build macro IDECODE_WB_FWD_EN enables same-cycle bypass of the WB result.
module idecode_sb
    import idecode_sb_pkg::*;
#(
    parameter int WORD   = 32,
    parameter int ADDR   = 32,
    parameter int NREG   = 8,
    parameter int W_OPC  = 6,
    parameter int W_DOPC = 4,
    parameter int W_IMM  = 16
) (
    input logic         clk,
    input logic         rst,
    idecode_sb_if.slave bus
);

    localparam int W_RD     = w_rd_of(NREG);
    localparam int IMMF_BIT = immf_bit(WORD, W_OPC);
    localparam int RD_LSB   = rd_lsb(WORD, W_OPC, W_RD);
    localparam int RS_LSB   = rs_lsb(WORD, W_OPC, W_RD);

    if (W_OPC + 1 + 2 * W_RD + W_IMM > WORD) begin : g_bad_layout
        $error("idecode_sb: instruction fields do not fit in WORD");
    end

    logic [W_OPC-1:0]  opc;
    logic              immf;
    logic [W_RD-1:0]   rd;
    logic [W_RD-1:0]   rs;
    logic [W_IMM-1:0]  imm;
    logic              wb_n;
    logic [W_DOPC-1:0] dopc_n;
    logic [WORD-1:0]   src_n;
    logic [WORD-1:0]   dest_n;

    logic rd_hz, rs_hz, rd_fwd, rs_fwd;
    logic hazard, ready, accept;

    logic              v_r;
    logic [WORD-1:0]   src_r;
    logic [WORD-1:0]   dest_r;
    logic              wb_r;
    logic [W_RD-1:0]   rd_r;
    logic [W_DOPC-1:0] dopc_r;
    logic [W_OPC-1:0]  opc_r;
    logic [ADDR-1:0]   addr_r;

    assign opc  = bus.inst_i[WORD-1 -: W_OPC];
    assign immf = bus.inst_i[IMMF_BIT];
    assign rd   = bus.inst_i[RD_LSB +: W_RD];
    assign rs   = bus.inst_i[RS_LSB +: W_RD];
    assign imm  = bus.inst_i[W_IMM-1:0];

    assign bus.r0_num_o = rd;
    assign bus.r1_num_o = rs;

    idecode_scoreboard #(.NREG(NREG), .W_RD(W_RD)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_v    (accept & wb_n),
        .set_num  (rd),
        .clr_v    (bus.wb_v_i),
        .clr_num  (bus.wb_num_i),
        .kill_v   (bus.flush_i & v_r & wb_r),
        .kill_num (rd_r),
        .rd_num   (rd),
        .rs_num   (rs),
        .rs_used  (~immf),
        .rd_hz    (rd_hz),
        .rs_hz    (rs_hz),
        .rd_fwd   (rd_fwd),
        .rs_fwd   (rs_fwd)
    );

    // Handshake: EX slot frees when empty or drained; a hazard holds IF off.
    always_comb begin
        hazard      = bus.v_i & (rd_hz | rs_hz);
        ready       = ~v_r | ~bus.stall_i;
        accept      = bus.v_i & ready & ~hazard & ~bus.flush_i;
        bus.stall_o = bus.v_i & ~(ready & ~hazard);
    end

    // Operand selection and opcode decode for the instruction on inst_i.
    always_comb begin
        wb_n   = has_wb(MAXW'(opc), W_OPC);
        dopc_n = W_DOPC'(decode_ope(MAXW'(opc), W_OPC));
        dest_n = rd_fwd ? bus.wb_data_i : bus.r0_data_i;
        if (immf) src_n = WORD'(expand_imm(MAXW'(imm), W_IMM, opc[W_OPC-1]));
        else      src_n = rs_fwd ? bus.wb_data_i : bus.r1_data_i;
    end

    // Valid bit: flush empties the slot even while EX is stalling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               v_r <= 1'b0;
        else if (bus.flush_i)  v_r <= 1'b0;
        else if (ready)        v_r <= accept;
    end

    // Payload registers load only on accept, so a stalled slot holds steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_r  <= '0;
            dest_r <= '0;
            wb_r   <= 1'b0;
            rd_r   <= '0;
            dopc_r <= '0;
            opc_r  <= '0;
            addr_r <= '0;
        end else if (accept) begin
            src_r  <= src_n;
            dest_r <= dest_n;
            wb_r   <= wb_n;
            rd_r   <= rd;
            dopc_r <= dopc_n;
            opc_r  <= opc;
            addr_r <= bus.origaddr_i;
        end
    end

    assign bus.v_o        = v_r;
    assign bus.src_o      = src_r;
    assign bus.dest_o     = dest_r;
    assign bus.wb_o       = wb_r;
    assign bus.rd_num_o   = rd_r;
    assign bus.dopc_o     = dopc_r;
    assign bus.opc_o      = opc_r;
    assign bus.origaddr_o = addr_r;

endmodule
